// File: rtl/csa5_frame_accum_ctrl.sv
// csa5_frame_accum_ctrl
// Packs a stream of unsigned 14-bit operands into groups of five. Each group goes through a
// 5:2 carry-save compressor, and one carry-propagate add folds it into a frame accumulator.
// At frame end the block presents the total and the operand count on an output handshake.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; in_data operand, in_last closes the frame
//   out_valid/out_ready      frame result handshake
//   out_sum [ACC_W]          frame sum
//   out_cnt [CNT_W]          operand count, modulo 2^CNT_W
//   out_ovf                  sticky accumulator overflow (saturating build only)
//
// Build option: define CSA_ACC_SAT_EN to make the accumulator saturate at 2^ACC_W-1 and
// report out_ovf. Without it the accumulator wraps and out_ovf is tied to 0.
module csa5_frame_accum_ctrl #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StCollect, StCompress, StResolve, StOutput} state_e;

  state_e           r_state;
  logic [13:0]      r_slot [5];
  logic [2:0]       r_idx;
  logic             r_last;
  logic [16:0]      r_cs1, r_cs2;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_ovf;

  logic             w_accept;
  logic [16:0]      w_op [5];
  logic [16:0]      w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
  logic [16:0]      w_grp_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  assign in_ready  = (r_state == StCollect) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cnt   = r_out_cnt;
  assign out_ovf   = r_out_ovf;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_op[i] = {3'b000, r_slot[i]};
    end
  end

  // Three chained 3:2 rows. No constant bias is injected, so cs1 + cs2 is the exact sum
  // modulo 2^17; the group sum (max 5*16383) always fits in 17 bits.
  assign w_s1 = w_op[0] ^ w_op[1] ^ w_op[2];
  assign w_c1 = ((w_op[0] & w_op[1]) | (w_op[0] & w_op[2]) | (w_op[1] & w_op[2])) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_op[3];
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_op[3]) | (w_c1 & w_op[3])) << 1;
  assign w_s3 = w_s2 ^ w_c2 ^ w_op[4];
  assign w_c3 = ((w_s2 & w_c2) | (w_s2 & w_op[4]) | (w_c2 & w_op[4])) << 1;

  // Truncating to 17 bits discards any carry-save wrap artefact.
  assign w_grp_sum = r_cs1 + r_cs2;

`ifdef CSA_ACC_SAT_EN
  logic             r_ovf;
  logic [ACC_W:0]   w_tot;
  assign w_tot     = {1'b0, r_acc} + (ACC_W+1)'(w_grp_sum);
  assign w_acc_nxt = w_tot[ACC_W] ? '1 : w_tot[ACC_W-1:0];
  assign w_ovf_nxt = r_ovf | w_tot[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == StResolve) begin
      r_ovf <= w_ovf_nxt;
    end else if (r_state == StOutput && out_ready) begin
      r_ovf <= 1'b0;
    end
  end
`else
  assign w_acc_nxt = r_acc + ACC_W'(w_grp_sum);
  assign w_ovf_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StCollect;
      for (int i = 0; i < 5; i++) r_slot[i] <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_cs1       <= '0;
      r_cs2       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StCollect: begin
          if (w_accept) begin
            r_slot[r_idx] <= in_data;
            r_idx         <= r_idx + 3'd1;
            r_cnt         <= r_cnt + 1'b1;
            // Unfilled slots are already zero: they are cleared after every group.
            if (r_idx == 3'd4 || in_last) begin
              r_last  <= in_last;
              r_state <= StCompress;
            end
          end
        end
        StCompress: begin
          r_cs1   <= w_s3;
          r_cs2   <= w_c3;
          r_state <= StResolve;
        end
        StResolve: begin
          r_acc <= w_acc_nxt;
          for (int i = 0; i < 5; i++) r_slot[i] <= '0;
          r_idx <= '0;
          if (r_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_nxt;
            r_out_cnt   <= r_cnt;
            r_out_ovf   <= w_ovf_nxt;
            r_state     <= StOutput;
          end else begin
            r_state <= StCollect;
          end
        end
        StOutput: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= StCollect;
          end
        end
        default: r_state <= StCollect;
      endcase
    end
  end

endmodule

// File: tb/tb_csa5_frame_accum_ctrl.sv
// Self-checking bench for csa5_frame_accum_ctrl. Directed frames push their expected result
// into a scoreboard queue; a monitor compares the presented result every cycle out_valid is
// high and pops it on the handshake. Define CSA_ACC_SAT_EN to match a saturating build.
module tb_csa5_frame_accum_ctrl;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [13:0]      in_data = '0;
  logic             out_ready = 1'b1;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  csa5_frame_accum_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, when all inputs have settled.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_low_in_output", 32'(in_ready), 32'd0);
      if (!prev_valid) chk("latency_edges", 32'(cyc - acc_cyc), 32'd2);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got sum %0d, expected no frame", out_sum);
      end else begin
        chk("out_sum", 32'(out_sum), 32'(sb[0].sum));
        chk("out_cnt", 32'(out_cnt), 32'(sb[0].cnt));
        chk("out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
        if (out_ready) void'(sb.pop_front());
      end
      prev_valid = !out_ready;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send_beat(input logic [13:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1");
    end
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [ACC_W-1:0] s, input int c, input logic o);
    exp_t e;
    e.sum = s;
    e.cnt = CNT_W'(c);
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [13:0] v[$], input logic [ACC_W-1:0] es,
                            input logic eo);
    push_exp(es, v.size(), eo);
    for (int i = 0; i < v.size(); i++) send_beat(v[i], (i == v.size() - 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] q[$];
    int n;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1+2+3+4+5
    q = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd5};
    send_frame(q, 20'd15, 1'b0);
    wait_drain();

    // 7 x 16383 = 114681; in_ready low exactly two cycles after the 5th beat
    push_exp(20'd114681, 7, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(14'd16383, 1'b0);
    chk("gap_ready_0", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("gap_ready_1", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("gap_ready_2", 32'(in_ready), 32'd1);
    send_beat(14'd16383, 1'b0);
    send_beat(14'd16383, 1'b1);
    wait_drain();

    // single operand, padding slots contribute 0
    q = '{14'h2AAA};
    send_frame(q, 20'd10922, 1'b0);
    wait_drain();

    // back-pressure: result held across 4 stalled cycles
    out_ready = 1'b0;
    q = '{14'd100, 14'd200, 14'd300};
    send_frame(q, 20'd600, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain();
    q = '{14'd7, 14'd8};
    send_frame(q, 20'd15, 1'b0);
    wait_drain();

    // reset while a partial frame is in RESOLVE
    for (int i = 0; i < 5; i++) send_beat(14'd1000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    q = '{14'd10, 14'd20};
    send_frame(q, 20'd30, 1'b0);
    wait_drain();

    // 65 x 16383 = 1064895 overflows a 20-bit accumulator
    q.delete();
    for (int i = 0; i < 65; i++) q.push_back(14'd16383);
`ifdef CSA_ACC_SAT_EN
    send_frame(q, 20'd1048575, 1'b1);
`else
    send_frame(q, 20'd16319, 1'b0);
`endif
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
